nios2_oci_dct_packer: RTL and testbench

// - Trace-atom packer directly upstream of the OCI test bench stage; produces the dct_buffer/dct_count pair it consumes.
// - Packs 2-bit trace atoms from the CPU trace tap into 30-bit frames of up to 15 atoms.
// - Hands each frame downstream over a valid/ready handshake.
// - Sequences end-of-test draining and drives test_ending/test_has_ended.

---
 rtl/nios2_oci_trace_pkg.sv | 22 ++
 rtl/nios2_oci_dct_outreg.sv | 45 ++++
 rtl/nios2_oci_dct_packer.sv | 163 ++++++++++++++++
 tb/tb_nios2_oci_dct_packer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_trace_pkg.sv
// Shared definitions for the OCI trace packer: atom encodings, default
// frame geometry and the end-of-test sequencing states.
package nios2_oci_trace_pkg;

   localparam int DEF_ATOM_W    = 2;
   localparam int DEF_ATOMS_MAX = 15;
   localparam int DEF_CNT_W     = 4;
   localparam int DEF_DROP_W    = 8;

   // 2'b00 carries no trace information and is never packed
   localparam logic [1:0] ATOM_NONE = 2'b00;
   localparam logic [1:0] ATOM_NT   = 2'b01;
   localparam logic [1:0] ATOM_TK   = 2'b10;
   localparam logic [1:0] ATOM_EXC  = 2'b11;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      ENDED = 2'd2
   } dct_state_e;

endpackage

// File: rtl/nios2_oci_dct_outreg.sv
// One-deep valid/ready holding register for a packed trace frame.
// Data reads as zero whenever no frame is offered.
module nios2_oci_dct_outreg
   import nios2_oci_trace_pkg::*;
#(
   parameter int BUF_W = DEF_ATOM_W * DEF_ATOMS_MAX,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [BUF_W-1:0] i_buf,
   input  logic [CNT_W-1:0] i_cnt,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [BUF_W-1:0] o_buf,
   output logic [CNT_W-1:0] o_cnt
);

   logic             r_valid;
   logic [BUF_W-1:0] r_buf;
   logic [CNT_W-1:0] r_cnt;

   // Load only arrives when the slot is free, so it wins over a same-cycle accept
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_valid <= 1'b0;
         r_buf   <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_buf   <= i_buf;
         r_cnt   <= i_cnt;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
         r_buf   <= '0;
         r_cnt   <= '0;
      end
   end

   assign o_valid = r_valid;
   assign o_buf   = r_buf;
   assign o_cnt   = r_cnt;

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into frames of up to ATOMS_MAX atoms, hands them
// downstream over valid/ready and sequences the end-of-test drain.
module nios2_oci_dct_packer
   import nios2_oci_trace_pkg::*;
#(
   parameter int ATOM_W    = DEF_ATOM_W,
   parameter int ATOMS_MAX = DEF_ATOMS_MAX,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int DROP_W    = DEF_DROP_W
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_atom_valid,
   input  logic [ATOM_W-1:0]           i_atom,
   input  logic                        i_flush,
   input  logic                        i_test_end_req,
   output logic [ATOM_W*ATOMS_MAX-1:0] o_dct_buffer,
   output logic [CNT_W-1:0]            o_dct_count,
   output logic                        o_frame_valid,
   input  logic                        i_frame_ready,
   output logic                        o_overflow,
   output logic [DROP_W-1:0]           o_drop_count,
   output logic                        o_test_ending,
   output logic                        o_test_has_ended
);

   localparam int               BUF_W    = ATOM_W * ATOMS_MAX;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ATOMS_MAX);

   dct_state_e        r_state;
   logic              r_test_ending;
   logic              r_test_has_ended;
   logic [BUF_W-1:0]  r_acc_buf;
   logic [CNT_W-1:0]  r_acc_cnt;
   logic              r_flush_pend;
   logic              r_overflow;
   logic [DROP_W-1:0] r_drop_count;

   logic              w_frame_valid;
   logic              w_slot_free;
   logic              w_full;
   logic              w_atom_ok;
   logic              w_flush_req;
   logic [BUF_W-1:0]  w_cat_buf;
   logic [CNT_W-1:0]  w_cat_cnt;
   logic [BUF_W-1:0]  w_nxt_buf;
   logic [CNT_W-1:0]  w_nxt_cnt;
   logic              w_load;
   logic              w_drop;

   assign w_slot_free = !w_frame_valid || i_frame_ready;
   assign w_full      = (r_acc_cnt == CNT_FULL);
   assign w_atom_ok   = i_atom_valid && (i_atom != '0) && (r_state == RUN);
   assign w_flush_req = i_flush || r_flush_pend || (r_state == DRAIN);

   // Accumulator contents including this cycle's atom (a full acc cannot take one)
   always_comb begin
      w_cat_buf = r_acc_buf;
      w_cat_cnt = r_acc_cnt;
      if (w_atom_ok && !w_full) begin
         w_cat_buf[int'(r_acc_cnt)*ATOM_W +: ATOM_W] = i_atom;
         w_cat_cnt = r_acc_cnt + CNT_W'(1);
      end
   end

   // Transfer/drop decision; a full acc that transfers restarts with the new atom
   always_comb begin
      w_load    = 1'b0;
      w_drop    = 1'b0;
      w_nxt_buf = w_cat_buf;
      w_nxt_cnt = w_cat_cnt;
      if (w_full) begin
         if (w_slot_free) begin
            w_load    = 1'b1;
            w_nxt_buf = '0;
            w_nxt_cnt = '0;
            if (w_atom_ok) begin
               w_nxt_buf[ATOM_W-1:0] = i_atom;
               w_nxt_cnt             = CNT_W'(1);
            end
         end else if (w_atom_ok) begin
            w_drop = 1'b1;
         end
      end else if (w_slot_free &&
                   ((w_cat_cnt == CNT_FULL) || (w_flush_req && (w_cat_cnt != '0)))) begin
         w_load    = 1'b1;
         w_nxt_buf = '0;
         w_nxt_cnt = '0;
      end
   end

   // Accumulator, pending flush and drop statistics
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_acc_buf    <= '0;
         r_acc_cnt    <= '0;
         r_flush_pend <= 1'b0;
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         r_acc_buf    <= w_nxt_buf;
         r_acc_cnt    <= w_nxt_cnt;
         r_flush_pend <= (i_flush || r_flush_pend) && (w_nxt_cnt != '0);
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) r_drop_count <= r_drop_count + DROP_W'(1);
         end
      end
   end

   // End-of-test sequencer with registered status outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state          <= RUN;
         r_test_ending    <= 1'b0;
         r_test_has_ended <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (i_test_end_req) begin
                  r_state       <= DRAIN;
                  r_test_ending <= 1'b1;
               end
            end
            DRAIN: begin
               if ((r_acc_cnt == '0) && w_slot_free) begin
                  r_state          <= ENDED;
                  r_test_ending    <= 1'b0;
                  r_test_has_ended <= 1'b1;
               end
            end
            ENDED: ;
            default: begin
               r_state          <= RUN;
               r_test_ending    <= 1'b0;
               r_test_has_ended <= 1'b0;
            end
         endcase
      end
   end

   nios2_oci_dct_outreg #(
      .BUF_W (BUF_W),
      .CNT_W (CNT_W)
   ) u_outreg (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (w_load),
      .i_buf   (w_cat_buf),
      .i_cnt   (w_cat_cnt),
      .i_ready (i_frame_ready),
      .o_valid (w_frame_valid),
      .o_buf   (o_dct_buffer),
      .o_cnt   (o_dct_count)
   );

   assign o_frame_valid    = w_frame_valid;
   assign o_overflow       = r_overflow;
   assign o_drop_count     = r_drop_count;
   assign o_test_ending    = r_test_ending;
   assign o_test_has_ended = r_test_has_ended;

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Directed bench for the trace-atom packer: a vector table for short
// flush/handshake sequences plus hand-written multi-cycle scenarios.
module tb_nios2_oci_dct_packer;
   import nios2_oci_trace_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        atom_valid = 1'b0;
   logic [1:0]  atom = 2'b00;
   logic        flush = 1'b0;
   logic        test_end_req = 1'b0;
   logic        frame_ready = 1'b1;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        frame_valid;
   logic        overflow;
   logic [7:0]  drop_count;
   logic        test_ending;
   logic        test_has_ended;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   nios2_oci_dct_packer #(
      .ATOM_W    (2),
      .ATOMS_MAX (15),
      .CNT_W     (4),
      .DROP_W    (8)
   ) dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_atom_valid     (atom_valid),
      .i_atom           (atom),
      .i_flush          (flush),
      .i_test_end_req   (test_end_req),
      .o_dct_buffer     (dct_buffer),
      .o_dct_count      (dct_count),
      .o_frame_valid    (frame_valid),
      .i_frame_ready    (frame_ready),
      .o_overflow       (overflow),
      .o_drop_count     (drop_count),
      .o_test_ending    (test_ending),
      .o_test_has_ended (test_has_ended)
   );

   typedef struct {
      logic        av;
      logic [1:0]  at;
      logic        fl;
      logic        rdy;
      logic        exp_v;
      logic [3:0]  exp_c;
      logic [29:0] exp_b;
   } vec_t;

   vec_t vt[13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_frame(input string name, input logic v, input logic [3:0] c, input logic [29:0] b);
      chk({name, ".valid"}, 32'(frame_valid), 32'(v));
      chk({name, ".count"}, 32'(dct_count), 32'(c));
      chk({name, ".buffer"}, 32'(dct_buffer), 32'(b));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      atom_valid = 1'b0;
      flush = 1'b0;
      test_end_req = 1'b0;
      frame_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic push(input logic [1:0] a);
      atom_valid = 1'b1;
      atom = a;
      tick();
      atom_valid = 1'b0;
   endtask

   initial begin
      // flush packing, empty flush, 00 atom, flush held while output blocked
      vt[0]  = '{1'b1, ATOM_NT,  1'b0, 1'b1, 1'b0, 4'd0, 30'h0};
      vt[1]  = '{1'b1, ATOM_TK,  1'b0, 1'b1, 1'b0, 4'd0, 30'h0};
      vt[2]  = '{1'b1, ATOM_EXC, 1'b1, 1'b1, 1'b1, 4'd3, 30'h39};
      vt[3]  = '{1'b0, 2'b00,    1'b0, 1'b1, 1'b0, 4'd0, 30'h0};
      vt[4]  = '{1'b0, 2'b00,    1'b1, 1'b1, 1'b0, 4'd0, 30'h0};
      vt[5]  = '{1'b1, 2'b00,    1'b1, 1'b1, 1'b0, 4'd0, 30'h0};
      vt[6]  = '{1'b0, 2'b00,    1'b0, 1'b1, 1'b0, 4'd0, 30'h0};
      vt[7]  = '{1'b1, ATOM_TK,  1'b1, 1'b0, 1'b1, 4'd1, 30'h2};
      vt[8]  = '{1'b1, ATOM_NT,  1'b1, 1'b0, 1'b1, 4'd1, 30'h2};
      vt[9]  = '{1'b0, 2'b00,    1'b0, 1'b0, 1'b1, 4'd1, 30'h2};
      vt[10] = '{1'b0, 2'b00,    1'b0, 1'b1, 1'b1, 4'd1, 30'h1};
      vt[11] = '{1'b0, 2'b00,    1'b0, 1'b1, 1'b0, 4'd0, 30'h0};
      vt[12] = '{1'b0, 2'b00,    1'b0, 1'b1, 1'b0, 4'd0, 30'h0};

      // reset state
      do_reset();
      chk_frame("reset", 1'b0, 4'd0, 30'h0);
      chk("reset.overflow", 32'(overflow), 32'd0);
      chk("reset.drop", 32'(drop_count), 32'd0);
      chk("reset.ending", 32'(test_ending), 32'd0);
      chk("reset.ended", 32'(test_has_ended), 32'd0);

      // table-driven vectors
      for (int i = 0; i < 13; i++) begin
         atom_valid  = vt[i].av;
         atom        = vt[i].at;
         flush       = vt[i].fl;
         frame_ready = vt[i].rdy;
         tick();
         chk_frame($sformatf("vec%0d", i), vt[i].exp_v, vt[i].exp_c, vt[i].exp_b);
      end
      flush = 1'b0;
      chk("vec.overflow", 32'(overflow), 32'd0);

      // 15 taken atoms -> full frame the cycle after the 15th
      do_reset();
      for (int i = 0; i < 14; i++) push(ATOM_TK);
      chk_frame("full14", 1'b0, 4'd0, 30'h0);
      push(ATOM_TK);
      chk_frame("full15", 1'b1, 4'd15, 30'h2AAAAAAA);
      tick();
      chk_frame("full_accepted", 1'b0, 4'd0, 30'h0);

      // blocked output: 31 atoms, last one dropped, then two frames drain
      do_reset();
      frame_ready = 1'b0;
      for (int i = 0; i < 15; i++) push(ATOM_NT);
      chk_frame("blk_first", 1'b1, 4'd15, 30'h15555555);
      for (int i = 0; i < 15; i++) push(ATOM_NT);
      chk("blk30.overflow", 32'(overflow), 32'd0);
      push(ATOM_NT);
      chk("blk31.overflow", 32'(overflow), 32'd1);
      chk("blk31.drop", 32'(drop_count), 32'd1);
      chk_frame("blk_held", 1'b1, 4'd15, 30'h15555555);
      frame_ready = 1'b1;
      tick();
      chk_frame("blk_second", 1'b1, 4'd15, 30'h15555555);
      tick();
      chk_frame("blk_done", 1'b0, 4'd0, 30'h0);
      tick();
      chk_frame("blk_no_third", 1'b0, 4'd0, 30'h0);
      chk("blk.overflow_sticky", 32'(overflow), 32'd1);

      // drop counter saturation: 15 + 15 kept, 270 dropped
      do_reset();
      frame_ready = 1'b0;
      for (int i = 0; i < 300; i++) push(ATOM_EXC);
      chk("sat.drop", 32'(drop_count), 32'd255);
      chk("sat.overflow", 32'(overflow), 32'd1);

      // end-of-test drain
      do_reset();
      for (int i = 0; i < 4; i++) push(ATOM_TK);
      test_end_req = 1'b1;
      tick();
      test_end_req = 1'b0;
      chk("drain.ending", 32'(test_ending), 32'd1);
      chk("drain.ended0", 32'(test_has_ended), 32'd0);
      chk_frame("drain_req", 1'b0, 4'd0, 30'h0);
      frame_ready = 1'b0;
      push(ATOM_EXC);
      chk_frame("drain_frame", 1'b1, 4'd4, 30'hAA);
      tick();
      chk_frame("drain_hold", 1'b1, 4'd4, 30'hAA);
      chk("drain_hold.ended", 32'(test_has_ended), 32'd0);
      frame_ready = 1'b1;
      tick();
      chk("ended.ended", 32'(test_has_ended), 32'd1);
      chk("ended.ending", 32'(test_ending), 32'd0);
      chk_frame("ended_accepted", 1'b0, 4'd0, 30'h0);
      for (int i = 0; i < 20; i++) push(ATOM_TK);
      test_end_req = 1'b1;
      flush = 1'b1;
      tick();
      test_end_req = 1'b0;
      flush = 1'b0;
      tick();
      chk_frame("ended_ignore", 1'b0, 4'd0, 30'h0);
      chk("ended_ignore.drop", 32'(drop_count), 32'd0);
      chk("ended_ignore.ended", 32'(test_has_ended), 32'd1);
      chk("ended_ignore.ending", 32'(test_ending), 32'd0);

      // reset mid-frame discards the partial frame
      do_reset();
      for (int i = 0; i < 7; i++) push(ATOM_NT);
      chk_frame("mid_partial", 1'b0, 4'd0, 30'h0);
      reset = 1'b1;
      atom_valid = 1'b1;
      atom = ATOM_NT;
      tick();
      reset = 1'b0;
      atom_valid = 1'b0;
      chk_frame("mid_reset", 1'b0, 4'd0, 30'h0);
      chk("mid_reset.overflow", 32'(overflow), 32'd0);
      chk("mid_reset.ending", 32'(test_ending), 32'd0);
      for (int i = 0; i < 14; i++) push(ATOM_EXC);
      chk_frame("mid14", 1'b0, 4'd0, 30'h0);
      push(ATOM_EXC);
      chk_frame("mid15", 1'b1, 4'd15, 30'h3FFFFFFF);
      tick();
      chk_frame("mid_only_one", 1'b0, 4'd0, 30'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
